// File: rtl/ddr3_wr_rank_scheduler.sv
// Schedules completed BRAM ranks into DDR3 bursts inside two ping-pong frame banks
// and publishes a frame descriptor per completed frame, dropping frames with no free bank.
module ddr3_wr_rank_scheduler #(
  parameter int          ADDR_W      = 27,
  parameter int unsigned FRAME_BEATS = 131072,
  parameter int          QDEPTH      = 4
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [1:0]        i_wr_rank,
  input  logic [7:0]        i_wr_128cnt,
  input  logic [5:0]        i_wr_bytecnt,
  input  logic              i_wr_last,
  output logic [3:0]        o_rank_busy,
  output logic              o_queue_full,
  output logic              o_burst_req,
  output logic [1:0]        o_burst_rank,
  output logic [ADDR_W-1:0] o_burst_addr,
  output logic [7:0]        o_burst_len,
  input  logic              i_burst_ack,
  input  logic              i_burst_done,
  output logic              o_frame_valid,
  output logic              o_frame_bank,
  output logic [ADDR_W-1:0] o_frame_base,
  output logic [23:0]       o_frame_bytes,
  input  logic [1:0]        i_frame_release,
  output logic [15:0]       o_drop_cnt,
  output logic [1:0]        o_err
);

  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W:0] FB_X = (ADDR_W+1)'(FRAME_BEATS);

  typedef struct packed {
    logic [1:0] rank;
    logic [7:0] cnt;
    logic [5:0] bcnt;
    logic       last;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

  state_t state_q, state_d;

  // An entry stays in the queue until it retires, so occupancy covers the rank in flight.
  desc_t         mem_q [QDEPTH];
  logic [QW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  desc_t         head;
  logic          q_full, q_empty, push;

  logic              cur_bank_q, active_q, dropping_q;
  logic [1:0]        full_q;
  logic [ADDR_W-1:0] offset_q;
  logic [23:0]       bytes_q;
  logic [3:0]        busy_q;
  logic [1:0]        err_q;
  logic [15:0]       drop_cnt_q;
  logic [1:0]        burst_rank_q;
  logic [ADDR_W-1:0] burst_addr_q;
  logic [7:0]        burst_len_q;
  logic              fv_q, fbank_q;
  logic [ADDR_W-1:0] fbase_q;
  logic [23:0]       fbytes_q;

  logic              pop, retire, burst_req;
  logic              bank_blk, drop_in, ovf, skip;
  logic [ADDR_W-1:0] base;
  logic [11:0]       rank_bytes;
  logic [24:0]       bytes_sum;
  logic [23:0]       bytes_nxt;

  assign head    = mem_q[rd_q];
  assign q_full  = (cnt_q == CW'(QDEPTH));
  assign q_empty = (cnt_q == '0);
  assign push    = i_wr_req & ~q_full;

  // Frame-open bank check only applies to the first entry of a frame.
  assign bank_blk   = ~active_q & full_q[cur_bank_q];
  assign drop_in    = dropping_q | bank_blk;
  assign ovf        = ~drop_in & (({1'b0, offset_q} + (ADDR_W+1)'(head.cnt)) > FB_X);
  assign skip       = drop_in | ovf;
  assign base       = cur_bank_q ? FB_X[ADDR_W-1:0] : '0;
  assign rank_bytes = (head.bcnt == '0) ? {head.cnt, 4'b0}
                                        : {head.cnt - 8'd1, 4'b0} + 12'(head.bcnt);
  assign bytes_sum  = {1'b0, bytes_q} + 25'(rank_bytes);
  assign bytes_nxt  = bytes_sum[24] ? 24'hFFFFFF : bytes_sum[23:0];

  always_ff @(posedge i_pclk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!q_empty) state_d = skip ? S_RETIRE : S_ISSUE;
      S_ISSUE:  if (i_burst_ack) state_d = i_burst_done ? S_RETIRE : S_WAIT;
      S_WAIT:   if (i_burst_done) state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    retire    = 1'b0;
    burst_req = 1'b0;
    case (state_q)
      S_IDLE:   pop       = ~q_empty;
      S_ISSUE:  burst_req = 1'b1;
      S_RETIRE: retire    = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (push) mem_q[wr_q] <= desc_t'{i_wr_rank, i_wr_128cnt, i_wr_bytecnt, i_wr_last};
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      cur_bank_q   <= 1'b0;
      active_q     <= 1'b0;
      dropping_q   <= 1'b0;
      full_q       <= '0;
      offset_q     <= '0;
      bytes_q      <= '0;
      busy_q       <= '0;
      err_q        <= '0;
      drop_cnt_q   <= '0;
      burst_rank_q <= '0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
      fv_q         <= 1'b0;
      fbank_q      <= 1'b0;
      fbase_q      <= '0;
      fbytes_q     <= '0;
    end else begin
      fv_q   <= 1'b0;
      busy_q <= (busy_q & ~(retire ? (4'b1 << head.rank) : 4'b0))
              | (push ? (4'b1 << i_wr_rank) : 4'b0);
      full_q <= (full_q & ~i_frame_release)
              | ((retire && head.last && !dropping_q) ? (2'b1 << cur_bank_q) : 2'b0);
      cnt_q  <= cnt_q + CW'(push) - CW'(retire);
      if (push) wr_q <= wr_q + 1'b1;
      if (i_wr_req && q_full) err_q[0] <= 1'b1;
      if (pop) begin
        active_q     <= 1'b1;
        dropping_q   <= skip;
        burst_rank_q <= head.rank;
        burst_addr_q <= base + offset_q;
        burst_len_q  <= head.cnt;
        if (ovf) err_q[1] <= 1'b1;
      end
      if (retire) begin
        rd_q     <= rd_q + 1'b1;
        offset_q <= offset_q + ADDR_W'(head.cnt);
        bytes_q  <= bytes_nxt;
        if (head.last) begin
          active_q   <= 1'b0;
          dropping_q <= 1'b0;
          offset_q   <= '0;
          bytes_q    <= '0;
          if (dropping_q) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          end else begin
            fv_q       <= 1'b1;
            fbank_q    <= cur_bank_q;
            fbase_q    <= base;
            fbytes_q   <= bytes_nxt;
            cur_bank_q <= ~cur_bank_q;
          end
        end
      end
    end
  end

  assign o_rank_busy   = busy_q;
  assign o_queue_full  = q_full;
  assign o_burst_req   = burst_req;
  assign o_burst_rank  = burst_rank_q;
  assign o_burst_addr  = burst_addr_q;
  assign o_burst_len   = burst_len_q;
  assign o_frame_valid = fv_q;
  assign o_frame_bank  = fbank_q;
  assign o_frame_base  = fbase_q;
  assign o_frame_bytes = fbytes_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_err         = err_q;

endmodule
